// File: rtl/dht_read_sequencer_pkg.sv
// Shared types and constants for the DHT11-class read sequencer.
package dht_pkg;

    localparam int DATA_BITS = 40;
    localparam int US_CNT_W  = 16;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_ACK,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK,
        FINISH
    } state_e;

    // Modulo-256 sum of the four payload bytes of a received frame.
    function automatic logic [7:0] checksum8(input logic [DATA_BITS-1:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

endpackage

// File: rtl/dht_read_sequencer_us_tick_gen.sv
// Restartable microsecond prescaler: tick is a one-clock enable every
// CLKS_PER_US clocks, and restart realigns the count to zero.
module us_tick_gen #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_US - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: wrap at CNT_MAX, jump back to zero on restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dht_read_sequencer.sv
// Single-wire DHT11-class read sequencer: drives the host start pulse,
// follows the sensor handshake, times each bit high phase in microseconds
// and returns the four data bytes plus checksum status.
module dht_read_sequencer
    import dht_pkg::*;
#(
    parameter int CLKS_PER_US      = 50,
    parameter int START_LOW_US     = 18000,
    parameter int TIMEOUT_US       = 200,
    parameter int BIT_THRESHOLD_US = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec
);

    localparam logic [US_CNT_W-1:0] START_LOW_CNT = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_CNT   = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0] THRESH_CNT    = US_CNT_W'(BIT_THRESHOLD_US);
    localparam logic [5:0]          LAST_BIT      = 6'(DATA_BITS - 1);

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic                  line_rise, line_fall;
    logic                  restart, us_tick, is_wait;
    logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d, us_now;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  sr_q, sr_d;
    logic                  error_q, error_d;
    logic [7:0]            hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]            temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;

    // Two-flop synchronizer plus a delayed copy for edge detection; idles high
    // like the pulled-up line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= dq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line_rise = sync2_q & ~prev_q;
    assign line_fall = ~sync2_q & prev_q;

    // Every state change restarts the timebase so each phase is timed from
    // its own entry.
    assign restart = (state_d != state_q);

    us_tick_gen #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_us_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (us_tick)
    );

    // us_now is the phase length including the current clock; edges are seen
    // one clock after phase entry would have aligned, so decisions use it.
    always_comb begin
        us_now = us_cnt_q;
        if (us_tick && (us_cnt_q != '1)) begin
            us_now = us_cnt_q + 1'b1;
        end
    end

    assign us_cnt_d = restart ? '0 : us_now;

    assign is_wait = (state_q inside {WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH});

    // Next-state, datapath updates and output decode of the protocol FSM.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        sr_d       = sr_q;
        error_d    = error_q;
        hum_int_d  = hum_int_q;
        hum_dec_d  = hum_dec_q;
        temp_int_d = temp_int_q;
        temp_dec_d = temp_dec_q;
        busy       = 1'b1;
        dq_oe      = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = START_LOW;
                    error_d = 1'b0;
                end
            end
            START_LOW: begin
                dq_oe = 1'b1;
                if (us_now >= START_LOW_CNT) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (line_fall) state_d = ACK_LOW;
            end
            ACK_LOW: begin
                if (line_rise) state_d = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (line_fall) begin
                    state_d   = BIT_LOW;
                    bit_idx_d = '0;
                end
            end
            BIT_LOW: begin
                if (line_rise) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (line_fall) begin
                    sr_d = {sr_q[DATA_BITS-2:0], (us_now > THRESH_CNT)};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = CHECK;
                    end else begin
                        state_d   = BIT_LOW;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                hum_int_d  = sr_q[39:32];
                hum_dec_d  = sr_q[31:24];
                temp_int_d = sr_q[23:16];
                temp_dec_d = sr_q[15:8];
                error_d    = (checksum8(sr_q) != sr_q[7:0]);
                state_d    = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled sensor aborts any wait phase; the partial frame is dropped.
        if (is_wait && (us_now >= TIMEOUT_CNT)) begin
            state_d   = FINISH;
            error_d   = 1'b1;
            sr_d      = sr_q;
            bit_idx_d = bit_idx_q;
        end
    end

    // State, timing and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            us_cnt_q   <= '0;
            bit_idx_q  <= '0;
            sr_q       <= '0;
            error_q    <= 1'b0;
            hum_int_q  <= '0;
            hum_dec_q  <= '0;
            temp_int_q <= '0;
            temp_dec_q <= '0;
        end else begin
            state_q    <= state_d;
            us_cnt_q   <= us_cnt_d;
            bit_idx_q  <= bit_idx_d;
            sr_q       <= sr_d;
            error_q    <= error_d;
            hum_int_q  <= hum_int_d;
            hum_dec_q  <= hum_dec_d;
            temp_int_q <= temp_int_d;
            temp_dec_q <= temp_dec_d;
        end
    end

    assign error    = error_q;
    assign hum_int  = hum_int_q;
    assign hum_dec  = hum_dec_q;
    assign temp_int = temp_int_q;
    assign temp_dec = temp_dec_q;

endmodule
